noc_pkt_arbiter2to1: RTL and testbench

- Packet-atomic 2:1 merge of two NoC flit streams onto one NoC injection port, with a registered 2-entry output buffer.
- Sits directly downstream of the two translator_in instances in the TCP stage and drives the router injection port.
- A flit train from one input is never interleaved with flits from the other.
- Round-robin fairness applies between packets, not between flits.

---
 rtl/noc_pkt_arbiter2to1.sv | 115 +++++++++++
 tb/tb_noc_pkt_arbiter2to1.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_pkt_arbiter2to1.sv
// Packet-atomic 2:1 NoC flit merge with round-robin between packets and a
// registered 2-entry output buffer feeding the router injection port.
module noc_pkt_arbiter2to1 #(
    parameter int NOC_WIDTH = 600,
    parameter int HEAD_POS  = NOC_WIDTH - 1,
    parameter int TAIL_POS  = NOC_WIDTH - 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NOC_WIDTH-1:0] i_data1_in,
    input  logic                 i_valid1_in,
    output logic                 i_ready1_out,
    input  logic [NOC_WIDTH-1:0] i_data2_in,
    input  logic                 i_valid2_in,
    output logic                 i_ready2_out,
    output logic [NOC_WIDTH-1:0] o_data_out,
    output logic                 o_valid_out,
    input  logic                 o_ready_in
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK1 = 2'd1;
    localparam logic [1:0] LOCK2 = 2'd2;

    logic [1:0]           state;
    logic                 last_grant2;
    logic [1:0]           count;
    logic [NOC_WIDTH-1:0] buf_head;
    logic [NOC_WIDTH-1:0] buf_tail;

    logic                 space;
    logic                 pick2;
    logic                 acc1;
    logic                 acc2;
    logic                 push;
    logic                 pop;
    logic                 push_tail;
    logic [NOC_WIDTH-1:0] push_data;

    // Space comes from the registered count only, so o_ready_in never reaches the input readys.
    assign space = (count != 2'd2);

    always_comb begin
        pick2        = i_valid2_in && (!i_valid1_in || !last_grant2);
        i_ready1_out = 1'b0;
        i_ready2_out = 1'b0;
        if (!reset) begin
            case (state)
                LOCK1:   i_ready1_out = space;
                LOCK2:   i_ready2_out = space;
                default: begin
                    i_ready1_out = space && i_valid1_in && !pick2;
                    i_ready2_out = space && pick2;
                end
            endcase
        end
    end

    assign acc1      = i_valid1_in && i_ready1_out;
    assign acc2      = i_valid2_in && i_ready2_out;
    assign push      = acc1 || acc2;
    assign push_data = acc2 ? i_data2_in : i_data1_in;
    assign push_tail = push_data[TAIL_POS];
    assign pop       = o_valid_out && o_ready_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_grant2 <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (push) begin
                        last_grant2 <= acc2;
                        if (!push_tail) begin
                            state <= acc2 ? LOCK2 : LOCK1;
                        end
                    end
                end
                LOCK1, LOCK2: begin
                    if (push && push_tail) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Push and pop together only happens at count==1, where the new flit becomes the head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= 2'd0;
            buf_head <= '0;
            buf_tail <= '0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (push && !pop) begin
                if (count == 2'd0) begin
                    buf_head <= push_data;
                end else begin
                    buf_tail <= push_data;
                end
            end else if (!push && pop) begin
                buf_head <= buf_tail;
            end else if (push && pop) begin
                buf_head <= push_data;
            end
        end
    end

    assign o_valid_out = (count != 2'd0);
    assign o_data_out  = buf_head;

endmodule

// File: tb/tb_noc_pkt_arbiter2to1.sv
// Bench for noc_pkt_arbiter2to1: queue-based arbiter/buffer model checked every
// cycle, an output scoreboard for order and packet atomicity, and directed scenarios.
module tb_noc_pkt_arbiter2to1;

    localparam int W = 600;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] d1, d2, od;
    logic         v1, v2, r1, r2, ov, rdy;

    noc_pkt_arbiter2to1 #(.NOC_WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_data1_in   (d1),
        .i_valid1_in  (v1),
        .i_ready1_out (r1),
        .i_data2_in   (d2),
        .i_valid2_in  (v2),
        .i_ready2_out (r2),
        .o_data_out   (od),
        .o_valid_out  (ov),
        .o_ready_in   (rdy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];
    bit           en1 = 0, en2 = 0, rdy_rand = 0;
    logic         rdy_val = 1'b1;
    int           vprob = 100, rprob = 100;
    int           seq1 = 0, seq2 = 0;

    int rel_cyc = 0;
    int in_src[$], in_cyc[$], out_src[$], out_cyc[$];

    int t1_src[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int t2_src[5] = '{0, 0, 0, 0, 1};

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qget(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    function automatic logic [W-1:0] mk_flit(input int src, input int seq, input bit head, input bit tail);
        logic [W-1:0] f;
        f = '0;
        for (int i = 32; i < W - 3; i++) f[i] = 1'($urandom_range(1));
        f[W-1]  = head;
        f[W-2]  = tail;
        f[W-3]  = (src == 2);
        f[31:0] = seq;
        return f;
    endfunction

    task automatic applyStimulus(input int src, input int len);
        for (int k = 0; k < len; k++) begin
            if (src == 1) begin
                q1.push_back(mk_flit(1, seq1, k == 0, k == len - 1));
                seq1++;
            end else begin
                q2.push_back(mk_flit(2, seq2, k == 0, k == len - 1));
                seq2++;
            end
        end
    endtask

    task automatic clear_logs();
        in_src.delete(); in_cyc.delete(); out_src.delete(); out_cyc.delete();
    endtask

    task automatic sync_start();
        @(posedge clk); #2;
        rel_cyc = 0;
    endtask

    task automatic drain(input int maxc);
        int k;
        k = 0;
        while ((q1.size() > 0 || q2.size() > 0 || v1 || v2 || ov) && k < maxc) begin
            @(negedge clk);
            k++;
        end
        checkOutput("drain_timeout", k < maxc, 1);
        #1;
    endtask

    // Upstream sources: hold a flit until accepted, then present the next one.
    initial begin
        bit hs1, hs2;
        v1 = 0; v2 = 0; d1 = '0; d2 = '0; rdy = 0;
        forever begin
            @(negedge clk);
            hs1 = v1 && r1;
            hs2 = v2 && r2;
            @(posedge clk); #1;
            if (hs1 && q1.size() > 0) void'(q1.pop_front());
            if (hs2 && q2.size() > 0) void'(q2.pop_front());
            if (!en1 || q1.size() == 0) v1 = 0;
            else if (!v1 || hs1) v1 = ($urandom_range(99) < vprob);
            if (!en2 || q2.size() == 0) v2 = 0;
            else if (!v2 || hs2) v2 = ($urandom_range(99) < vprob);
            d1 = (q1.size() > 0) ? q1[0] : '0;
            d2 = (q2.size() > 0) ? q2[0] : '0;
            rdy = rdy_rand ? ($urandom_range(99) < rprob) : rdy_val;
        end
    end

    // Reference model (locked input, last winner, FIFO queue) plus output scoreboard.
    initial begin
        logic [W-1:0] mq[$];
        logic [W-1:0] f;
        int  lock, last, cand, src, seq, cur_pkt;
        int  exp_seq[2];
        bit  resync[2];
        bit  space, er1, er2, acc1, acc2;
        lock = 0; last = 2; cur_pkt = -1;
        resync[0] = 1; resync[1] = 1; exp_seq[0] = 0; exp_seq[1] = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mq.delete();
                lock = 0; last = 2; cur_pkt = -1;
                resync[0] = 1; resync[1] = 1;
                checkOutput("rst_ready1", r1, 0);
                checkOutput("rst_ready2", r2, 0);
                checkOutput("rst_valid", ov, 0);
            end else begin
                space = (mq.size() < 2);
                er1 = 0; er2 = 0;
                if (lock == 1) er1 = space;
                else if (lock == 2) er2 = space;
                else begin
                    cand = (v1 && v2) ? ((last == 1) ? 2 : 1) : (v1 ? 1 : (v2 ? 2 : 0));
                    er1 = (cand == 1) && space;
                    er2 = (cand == 2) && space;
                end
                checkOutput("ready1", r1, er1);
                checkOutput("ready2", r2, er2);
                checkOutput("out_valid", ov, mq.size() > 0);
                if (mq.size() > 0) checkOutput("out_data", od, mq[0]);

                if (v1 && r1) begin in_src.push_back(0); in_cyc.push_back(rel_cyc); end
                if (v2 && r2) begin in_src.push_back(1); in_cyc.push_back(rel_cyc); end

                if (ov && rdy) begin
                    f   = od;
                    src = int'(f[W-3]);
                    seq = int'(f[31:0]);
                    out_src.push_back(src);
                    out_cyc.push_back(rel_cyc);
                    if (resync[src]) resync[src] = 0;
                    else checkOutput("out_seq_order", seq, exp_seq[src]);
                    exp_seq[src] = seq + 1;
                    if (cur_pkt == -1) checkOutput("out_head_flag", f[W-1], 1);
                    else checkOutput("out_no_interleave", src, cur_pkt);
                    cur_pkt = f[W-2] ? -1 : src;
                end

                acc1 = v1 && er1;
                acc2 = v2 && er2;
                if (mq.size() > 0 && rdy) void'(mq.pop_front());
                if (acc1 || acc2) begin
                    f = acc1 ? d1 : d2;
                    mq.push_back(f);
                    src = acc1 ? 1 : 2;
                    if (lock == 0) begin
                        last = src;
                        if (!f[W-2]) lock = src;
                    end else if (f[W-2]) begin
                        lock = 0;
                    end
                end
            end
            rel_cyc++;
        end
    end

    initial begin
        #900_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] first;
        int tot;
        reset = 1'b1;

        // Alternating single-flit packets; readys stay low while reset is held.
        @(negedge clk); #1;
        for (int k = 0; k < 4; k++) begin applyStimulus(1, 1); applyStimulus(2, 1); end
        en1 = 1; en2 = 1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("lit_rst_ready1", r1, 0);
        checkOutput("lit_rst_ready2", r2, 0);
        checkOutput("lit_rst_valid", ov, 0);
        checkOutput("lit_rst_data", od, 0);
        clear_logs();
        @(posedge clk); #2;
        reset = 1'b0;
        rel_cyc = 0;
        drain(200);
        checkOutput("t1_count", out_src.size(), 8);
        for (int k = 0; k < 8; k++) begin
            checkOutput("t1_src", qget(out_src, k), t1_src[k]);
            checkOutput("t1_cycle", qget(out_cyc, k), k + 1);
        end

        // 4-flit packet on input 1 holds off input 2 until its tail.
        clear_logs();
        en2 = 0;
        applyStimulus(1, 4);
        applyStimulus(2, 1);
        sync_start();
        en2 = 1;
        drain(200);
        for (int k = 0; k < 5; k++) begin
            checkOutput("t2_in_src", qget(in_src, k), t2_src[k]);
            checkOutput("t2_in_cycle", qget(in_cyc, k), k);
            checkOutput("t2_out_src", qget(out_src, k), t2_src[k]);
        end

        // Output stalled for 5 cycles: two flits fill the buffer, then backpressure.
        clear_logs();
        rdy_val = 1'b0;
        applyStimulus(1, 6);
        first = q1[0];
        sync_start();
        repeat (5) @(negedge clk);
        #1;
        checkOutput("t3_head_held", od, first);
        checkOutput("t3_ready1_low", r1, 0);
        checkOutput("t3_accepted", in_src.size(), 2);
        rdy_val = 1'b1;
        drain(200);
        checkOutput("t3_out_count", out_src.size(), 6);

        // Input 2 alone back-to-back, then input 1 wins the next tie.
        clear_logs();
        for (int k = 0; k < 3; k++) applyStimulus(2, 1);
        sync_start();
        drain(200);
        for (int k = 0; k < 3; k++) begin
            checkOutput("t4_in_src", qget(in_src, k), 1);
            checkOutput("t4_in_cycle", qget(in_cyc, k), k);
        end
        clear_logs();
        applyStimulus(1, 1);
        applyStimulus(2, 1);
        sync_start();
        drain(200);
        checkOutput("t4_tie_first", qget(in_src, 0), 0);
        checkOutput("t4_tie_second", qget(in_src, 1), 1);
        checkOutput("t4_tie_cycle", qget(in_cyc, 1), 1);

        // Asynchronous reset mid-packet, then a fresh input-2 packet from IDLE.
        clear_logs();
        applyStimulus(1, 3);
        sync_start();
        @(posedge clk); #1;
        checkOutput("t5_valid_before", ov, 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t5_valid_now", ov, 0);
        checkOutput("t5_ready1_now", r1, 0);
        checkOutput("t5_ready2_now", r2, 0);
        q1.delete();
        repeat (2) @(negedge clk);
        #1;
        clear_logs();
        applyStimulus(2, 2);
        @(posedge clk); #2;
        reset = 1'b0;
        rel_cyc = 0;
        drain(200);
        checkOutput("t5_in_src0", qget(in_src, 0), 1);
        checkOutput("t5_in_cyc0", qget(in_cyc, 0), 0);
        checkOutput("t5_in_src1", qget(in_src, 1), 1);
        checkOutput("t5_out_count", out_src.size(), 2);

        // Random valid/ready traffic, mixed packet lengths.
        clear_logs();
        tot = 0;
        while (tot < 10000) begin
            int len, s;
            len = $urandom_range(8, 1);
            s   = $urandom_range(2, 1);
            applyStimulus(s, len);
            tot += len;
        end
        vprob = 80; rprob = 75; rdy_rand = 1;
        drain(60000);
        checkOutput("t6_out_count", out_src.size(), tot);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
